// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: zero-register ID, opcode set
// and the packed ID/EX bundle.
package id_ex_stage_pkg;

    localparam int unsigned IdDataW = 16;
    localparam int unsigned IdRegW  = 4;

    localparam logic [IdRegW-1:0] ZeroReg = '0;

    typedef enum logic [3:0] {
        OpAdd    = 4'h0,
        OpSub    = 4'h1,
        OpXor    = 4'h2,
        OpRed    = 4'h3,
        OpSll    = 4'h4,
        OpSra    = 4'h5,
        OpRor    = 4'h6,
        OpPaddsb = 4'h7,
        OpLw     = 4'h8,
        OpSw     = 4'h9,
        OpLhb    = 4'hA,
        OpLlb    = 4'hB,
        OpB      = 4'hC,
        OpCall   = 4'hD,
        OpRet    = 4'hE,
        OpHlt    = 4'hF
    } opcode_e;

    typedef struct packed {
        logic               valid;
        logic [IdRegW-1:0]  src1;
        logic [IdRegW-1:0]  src2;
        logic [IdRegW-1:0]  dst;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               lb_ins;
        opcode_e            opcode;
        logic [IdDataW-1:0] rdata1;
        logic [IdDataW-1:0] rdata2;
        logic [IdDataW-1:0] imm;
    } id_ex_t;

    // A bubble carries dst=0, so downstream forwarding never matches it.
    localparam id_ex_t IdExBubble = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detection: a load in EX whose result is needed
// by the instruction in ID and that forwarding cannot deliver in time.
module id_ex_stage_load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REG_W = IdRegW
) (
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_uses_src1_i,
    input  logic             id_uses_src2_i,
    input  logic             id_memwrite_i,
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic             ex_regwrite_i,
    input  logic [REG_W-1:0] ex_dst_i,
    input  logic             flush_i,
    output logic             hz_o,
    output logic             load_use_stall_o
);

    logic m1;
    logic m2s;

    always_comb begin
        m1  = id_uses_src1_i & (id_src1_i == ex_dst_i);
        // Store data from a load is covered by MEM-to-MEM forwarding.
        m2s = id_uses_src2_i & (id_src2_i == ex_dst_i) & ~id_memwrite_i;
        hz_o = id_valid_i & ex_valid_i & ex_memread_i & ex_regwrite_i
             & (ex_dst_i != REG_W'(ZeroReg)) & (m1 | m2s);
        load_use_stall_o = hz_o & ~flush_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with built-in load-use bubble insertion, front-end
// hold and a saturating stall-cycle counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = IdDataW,
    parameter int unsigned REG_W  = IdRegW,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [REG_W-1:0]  id_dst,
    input  logic              id_uses_src1,
    input  logic              id_uses_src2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_lb_ins,
    input  logic [3:0]        id_opcode,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_src1,
    output logic [REG_W-1:0]  ex_src2,
    output logic [REG_W-1:0]  ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_lb_ins,
    output logic [3:0]        ex_opcode,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              load_use_stall,
    output logic              front_hold,
    output logic [CNT_W-1:0]  stall_cnt
);

    id_ex_t           stage_q, stage_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             hz;

    id_ex_stage_load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .id_valid_i       (id_valid),
        .id_src1_i        (id_src1),
        .id_src2_i        (id_src2),
        .id_uses_src1_i   (id_uses_src1),
        .id_uses_src2_i   (id_uses_src2),
        .id_memwrite_i    (id_memwrite),
        .ex_valid_i       (stage_q.valid),
        .ex_memread_i     (stage_q.memread),
        .ex_regwrite_i    (stage_q.regwrite),
        .ex_dst_i         (stage_q.dst),
        .flush_i          (flush),
        .hz_o             (hz),
        .load_use_stall_o (load_use_stall)
    );

    assign front_hold = load_use_stall | ext_stall;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = IdExBubble;
        end else if (ext_stall) begin
            stage_d = stage_q;
        end else if (hz) begin
            stage_d = IdExBubble;
        end else begin
            stage_d.valid    = id_valid;
            stage_d.src1     = id_src1;
            stage_d.src2     = id_src2;
            stage_d.dst      = id_dst;
            // Side-effecting controls are squashed for non-instructions.
            stage_d.regwrite = id_regwrite & id_valid;
            stage_d.memread  = id_memread & id_valid;
            stage_d.memwrite = id_memwrite & id_valid;
            stage_d.lb_ins   = id_lb_ins;
            stage_d.opcode   = opcode_e'(id_opcode);
            stage_d.rdata1   = id_rdata1;
            stage_d.rdata2   = id_rdata2;
            stage_d.imm      = id_imm;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use_stall && !ext_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q     <= IdExBubble;
            stall_cnt_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid    = stage_q.valid;
    assign ex_src1     = stage_q.src1;
    assign ex_src2     = stage_q.src2;
    assign ex_dst      = stage_q.dst;
    assign ex_regwrite = stage_q.regwrite;
    assign ex_memread  = stage_q.memread;
    assign ex_memwrite = stage_q.memwrite;
    assign ex_lb_ins   = stage_q.lb_ins;
    assign ex_opcode   = stage_q.opcode;
    assign ex_rdata1   = stage_q.rdata1;
    assign ex_rdata2   = stage_q.rdata2;
    assign ex_imm      = stage_q.imm;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use scenarios plus random traffic checked
// against a cycle-level reference model. Counter is narrowed so saturation is reachable.
module tb_id_ex_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_src1, id_uses_src2;
    logic [RW-1:0] id_src1, id_src2, id_dst;
    logic          id_regwrite, id_memread, id_memwrite, id_lb_ins;
    logic [3:0]    id_opcode;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
    logic          flush, ext_stall;
    logic          ex_valid;
    logic [RW-1:0] ex_src1, ex_src2, ex_dst;
    logic          ex_regwrite, ex_memread, ex_memwrite, ex_lb_ins;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm;
    logic          load_use_stall, front_hold;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: what EX should hold, and the stall count.
    typedef struct {
        logic          valid;
        logic [RW-1:0] src1, src2, dst;
        logic          rw, mr, mw, lb;
        logic [3:0]    op;
        logic [DW-1:0] rd1, rd2, imm;
        int            cnt;
    } model_t;

    model_t m, m_next;

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W (DW),
        .REG_W  (RW),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_dst         (id_dst),
        .id_uses_src1   (id_uses_src1),
        .id_uses_src2   (id_uses_src2),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_lb_ins      (id_lb_ins),
        .id_opcode      (id_opcode),
        .id_rdata1      (id_rdata1),
        .id_rdata2      (id_rdata2),
        .id_imm         (id_imm),
        .flush          (flush),
        .ext_stall      (ext_stall),
        .ex_valid       (ex_valid),
        .ex_src1        (ex_src1),
        .ex_src2        (ex_src2),
        .ex_dst         (ex_dst),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_lb_ins      (ex_lb_ins),
        .ex_opcode      (ex_opcode),
        .ex_rdata1      (ex_rdata1),
        .ex_rdata2      (ex_rdata2),
        .ex_imm         (ex_imm),
        .load_use_stall (load_use_stall),
        .front_hold     (front_hold),
        .stall_cnt      (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic model_t model_clear();
        model_t z;
        z = '{valid: 1'b0, src1: '0, src2: '0, dst: '0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
              lb: 1'b0, op: '0, rd1: '0, rd2: '0, imm: '0, cnt: 0};
        return z;
    endfunction

    // A dependent consumer in ID needs a loaded value the pipeline cannot supply yet.
    function automatic logic model_hazard();
        logic needs1, needs2;
        if (!(id_valid && m.valid && m.mr && m.rw && m.dst != 0)) return 1'b0;
        needs1 = id_uses_src1 && id_src1 == m.dst;
        needs2 = id_uses_src2 && id_src2 == m.dst && !id_memwrite;
        return needs1 || needs2;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, ".src1"}, 32'(ex_src1), 32'(m.src1));
        chk({tag, ".src2"}, 32'(ex_src2), 32'(m.src2));
        chk({tag, ".dst"}, 32'(ex_dst), 32'(m.dst));
        chk({tag, ".rw"}, 32'(ex_regwrite), 32'(m.rw));
        chk({tag, ".mr"}, 32'(ex_memread), 32'(m.mr));
        chk({tag, ".mw"}, 32'(ex_memwrite), 32'(m.mw));
        chk({tag, ".lb"}, 32'(ex_lb_ins), 32'(m.lb));
        chk({tag, ".op"}, 32'(ex_opcode), 32'(m.op));
        chk({tag, ".rd1"}, 32'(ex_rdata1), 32'(m.rd1));
        chk({tag, ".rd2"}, 32'(ex_rdata2), 32'(m.rd2));
        chk({tag, ".imm"}, 32'(ex_imm), 32'(m.imm));
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m.cnt));
    endtask

    // Check combinational outputs, advance model, clock once, check registers.
    task automatic cycle(input string tag);
        logic hz, stall;
        #1;
        hz = model_hazard();
        stall = hz && !flush;
        chk({tag, ".stall"}, 32'(load_use_stall), 32'(stall));
        chk({tag, ".hold"}, 32'(front_hold), 32'(stall || ext_stall));
        m_next = m;
        if (flush || (!ext_stall && hz)) begin
            m_next = model_clear();
            m_next.cnt = m.cnt;
        end else if (!ext_stall) begin
            m_next.valid = id_valid;
            m_next.src1 = id_src1;
            m_next.src2 = id_src2;
            m_next.dst = id_dst;
            m_next.rw = id_regwrite && id_valid;
            m_next.mr = id_memread && id_valid;
            m_next.mw = id_memwrite && id_valid;
            m_next.lb = id_lb_ins;
            m_next.op = id_opcode;
            m_next.rd1 = id_rdata1;
            m_next.rd2 = id_rdata2;
            m_next.imm = id_imm;
        end
        if (stall && !ext_stall && m.cnt < CNT_MAX) m_next.cnt = m.cnt + 1;
        @(posedge clk);
        #1;
        m = m_next;
        check_regs(tag);
    endtask

    task automatic set_id(input logic v, input int s1, input int s2, input int d,
                          input logic u1, input logic u2, input logic rw, input logic mr,
                          input logic mw, input logic [3:0] op);
        id_valid = v;
        id_src1 = RW'(s1);
        id_src2 = RW'(s2);
        id_dst = RW'(d);
        id_uses_src1 = u1;
        id_uses_src2 = u2;
        id_regwrite = rw;
        id_memread = mr;
        id_memwrite = mw;
        id_lb_ins = 1'b0;
        id_opcode = op;
        id_rdata1 = DW'($urandom);
        id_rdata2 = DW'($urandom);
        id_imm = DW'($urandom);
        flush = 1'b0;
        ext_stall = 1'b0;
    endtask

    // Load into rd from base r1; ADD rd <- rs1 + rs2.
    task automatic set_load(input int d);
        set_id(1'b1, 1, 0, d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8);
    endtask

    task automatic set_add(input int s1, input int s2, input int d);
        set_id(1'b1, s1, s2, d, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    int cnt_before;

    initial begin
        rst = 1'b1;
        set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        m = model_clear();
        #12;
        check_regs("reset");
        chk("reset.stall", 32'(load_use_stall), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: load R3 followed by dependent ADD
        set_load(3);
        cycle("t1.load");
        set_add(3, 4, 6);
        cycle("t1.bubble");
        chk("t1.ex_valid", 32'(ex_valid), 32'd0);
        chk("t1.ex_dst", 32'(ex_dst), 32'd0);
        chk("t1.cnt", 32'(stall_cnt), 32'd1);
        cycle("t1.add");
        chk("t1.ex_src1", 32'(ex_src1), 32'd3);
        chk("t1.ex_valid2", 32'(ex_valid), 32'd1);

        // 2: store of loaded data (src2) does not stall
        set_load(3);
        cycle("t2.load");
        set_id(1'b1, 5, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h9);
        #1;
        chk("t2.no_stall", 32'(load_use_stall), 32'd0);
        cycle("t2.store");
        chk("t2.ex_mw", 32'(ex_memwrite), 32'd1);
        chk("t2.cnt", 32'(stall_cnt), 32'd1);

        // 3: load to R0 never stalls
        set_load(0);
        cycle("t3.load");
        set_add(0, 0, 2);
        #1;
        chk("t3.no_stall", 32'(load_use_stall), 32'd0);
        cycle("t3.add");

        // 4a: hazard with flush -> flush wins
        set_load(3);
        cycle("t4.load");
        set_add(3, 2, 5);
        flush = 1'b1;
        #1;
        chk("t4.flush_nostall", 32'(load_use_stall), 32'd0);
        cycle("t4.flush");
        chk("t4.flush_cnt", 32'(stall_cnt), 32'd1);

        // 4b: hazard with ext_stall -> hold, then one bubble on release
        set_load(3);
        cycle("t4.load2");
        set_add(3, 2, 5);
        ext_stall = 1'b1;
        cycle("t4.ext");
        chk("t4.ext_mr", 32'(ex_memread), 32'd1);
        chk("t4.ext_dst", 32'(ex_dst), 32'd3);
        chk("t4.ext_cnt", 32'(stall_cnt), 32'd1);
        ext_stall = 1'b0;
        cycle("t4.release");
        chk("t4.rel_valid", 32'(ex_valid), 32'd0);
        chk("t4.rel_cnt", 32'(stall_cnt), 32'd2);
        cycle("t4.advance");

        // 5: drive the counter into saturation
        for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
            set_load(7);
            cycle("t5.load");
            set_add(1, 7, 8);
            cycle("t5.stall");
            cycle("t5.add");
        end
        chk("t5.sat", 32'(stall_cnt), 32'(CNT_MAX));

        // 6: asynchronous reset in the middle of a stall
        set_load(3);
        cycle("t6.load");
        set_add(3, 1, 9);
        #1;
        chk("t6.pre_stall", 32'(load_use_stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        m = model_clear();
        check_regs("t6.rst");
        chk("t6.rst_stall", 32'(load_use_stall), 32'd0);
        rst = 1'b0;
        cycle("t6.resume");
        chk("t6.resume_src1", 32'(ex_src1), 32'd3);

        // Random traffic over a small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            set_id(($urandom_range(0, 99) < 85), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 99) < 45), 1'($urandom), 4'($urandom));
            id_lb_ins = 1'($urandom);
            flush = ($urandom_range(0, 99) < 10);
            ext_stall = ($urandom_range(0, 99) < 15);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
